exec_mem_master: RTL and testbench

//  EXEC-side memory initiator. Accepts one memory command at a time from the EXEC sequencer
//  (READ, WRITE, or ISZ read-increment-write) and drives the EXEC read/write ports of the memory

---
 rtl/exec_mem_master.sv | 129 ++++++++++++
 tb/tb_exec_mem_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_master.sv
// EXEC-side memory initiator: runs one READ, WRITE or ISZ (read, increment, write back)
// command at a time against the memory unit's EXEC ports and pulses done on completion.
module exec_mem_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              skip,
  output logic              exec_rd_req,
  output logic [ADDR_W-1:0] exec_rd_addr,
  input  logic [DATA_W-1:0] exec_rd_data,
  output logic              exec_wr_req,
  output logic [ADDR_W-1:0] exec_wr_addr,
  output logic [DATA_W-1:0] exec_wr_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ISZ   = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              skip_q, skip_d;
  logic [DATA_W-1:0] sum;

  // ISZ increment wraps modulo 2^DATA_W, so all-ones becomes zero.
  function automatic logic [DATA_W-1:0] incr_wrap(input logic [DATA_W-1:0] v);
    incr_wrap = v + DATA_W'(1);
  endfunction

  assign sum = incr_wrap(exec_rd_data);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    skip_d  = skip_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          err_d   = 1'b0;
          case (cmd_op)
            OP_READ, OP_ISZ: state_d = S_RD;
            OP_WRITE:        state_d = S_WR;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
              skip_d  = 1'b0;
            end
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (op_q == OP_ISZ) begin
          wdata_d = sum;
          rdata_d = sum;
          skip_d  = (sum == '0);
          state_d = S_WR;
        end else begin
          rdata_d = exec_rd_data;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architecturally visible result registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      skip_q  <= skip_d;
    end
  end

  // Latched command fields are only observed through gated outputs, so they need no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign cmd_ready    = (state_q == S_IDLE) & ~reset;
  assign done         = (state_q == S_DONE);
  assign err          = done & err_q;
  assign rdata        = rdata_q;
  assign skip         = skip_q;
  assign exec_rd_req  = (state_q == S_RD);
  assign exec_rd_addr = exec_rd_req ? addr_q : '0;
  assign exec_wr_req  = (state_q == S_WR);
  assign exec_wr_addr = exec_wr_req ? addr_q : '0;
  assign exec_wr_data = exec_wr_req ? wdata_q : '0;

endmodule

// File: tb/tb_exec_mem_master.sv
// Randomized bench for exec_mem_master: a memory array answers reads one cycle late and
// a command-level model predicts request timing, write data, rdata, skip and err.
module tb_exec_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [11:0] cmd_wdata;
  logic        done;
  logic        err;
  logic [11:0] rdata;
  logic        skip;
  logic        exec_rd_req;
  logic [11:0] exec_rd_addr;
  logic [11:0] exec_rd_data;
  logic        exec_wr_req;
  logic [11:0] exec_wr_addr;
  logic [11:0] exec_wr_data;

  logic [11:0] mem [4096];
  logic [11:0] m_rdata;
  logic        m_skip;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  exec_mem_master #(.ADDR_W(12), .DATA_W(12)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .err(err), .rdata(rdata), .skip(skip),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data)
  );

  // Read data is valid only in the cycle after the request; otherwise it is noise.
  always @(posedge clk)
    exec_rd_data <= exec_rd_req ? mem[exec_rd_addr] : 12'($urandom);

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command at a negedge and follow it cycle by cycle until one cycle past done.
  task automatic run_cmd(input logic [1:0] op, input logic [11:0] addr,
                         input logic [11:0] wd, input bit hold);
    logic [11:0] old, sum, e_wdata, e_rdata, rd_a, wr_a, wr_d, g_rdata;
    logic        e_skip, e_err, g_err, g_skip;
    int          e_rd, e_wr, e_done, rd_n, wr_n, rd_c, wr_c, done_c, done_n;
    old = mem[addr];
    sum = old + 12'd1;
    e_wdata = 12'd0; e_err = 1'b0; e_rdata = m_rdata; e_skip = m_skip;
    case (op)
      2'b00: begin e_rd = 1; e_wr = -1; e_done = 3; e_rdata = old; end
      2'b01: begin e_rd = -1; e_wr = 1; e_done = 2; e_wdata = wd; end
      2'b10: begin e_rd = 1; e_wr = 3; e_done = 4; e_wdata = sum; e_rdata = sum;
                   e_skip = (sum == 12'd0); end
      default: begin e_rd = -1; e_wr = -1; e_done = 1; e_err = 1'b1; e_skip = 1'b0; end
    endcase
    rd_n = 0; wr_n = 0; rd_c = -1; wr_c = -1; done_c = -1; done_n = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; g_rdata = 0; g_err = 0; g_skip = 0;
    chk("ready_before", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (exec_rd_req) begin
        rd_n++; rd_c = c; rd_a = exec_rd_addr;
      end else chk("rd_addr_idle", int'(exec_rd_addr), 0);
      if (exec_wr_req) begin
        wr_n++; wr_c = c; wr_a = exec_wr_addr; wr_d = exec_wr_data;
        mem[exec_wr_addr] = exec_wr_data;
      end else begin
        chk("wr_addr_idle", int'(exec_wr_addr), 0);
        chk("wr_data_idle", int'(exec_wr_data), 0);
      end
      chk("rd_wr_excl", int'(exec_rd_req & exec_wr_req), 0);
      if (done) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c; g_rdata = rdata; g_err = err; g_skip = skip;
        end
      end
      if (done_c < 0 || c == done_c) chk("busy_ready", int'(cmd_ready), 0);
      else chk("ready_after", int'(cmd_ready), 1);
      if (done_c >= 0 || !hold) cmd_valid = 1'b0;
      else begin
        cmd_op = 2'($urandom); cmd_addr = 12'($urandom); cmd_wdata = 12'($urandom);
      end
      if (done_c >= 0 && c > done_c) break;
    end
    cmd_valid = 1'b0;
    chk("done_cycle", done_c, e_done);
    chk("done_count", done_n, 1);
    chk("rd_count", rd_n, (e_rd < 0) ? 0 : 1);
    chk("wr_count", wr_n, (e_wr < 0) ? 0 : 1);
    if (e_rd > 0) begin
      chk("rd_cycle", rd_c, e_rd);
      chk("rd_addr", int'(rd_a), int'(addr));
    end
    if (e_wr > 0) begin
      chk("wr_cycle", wr_c, e_wr);
      chk("wr_addr", int'(wr_a), int'(addr));
      chk("wr_data", int'(wr_d), int'(e_wdata));
    end
    chk("err", int'(g_err), int'(e_err));
    chk("rdata", int'(g_rdata), int'(e_rdata));
    chk("skip", int'(g_skip), int'(e_skip));
    m_rdata = e_rdata;
    m_skip  = e_skip;
  endtask

  task automatic reset_mid_isz(input logic [11:0] addr);
    logic [11:0] old;
    old = mem[addr];
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = addr; cmd_wdata = 12'd0;
    @(negedge clk);
    chk("abort_rd_req", int'(exec_rd_req), 1);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_reset", int'(cmd_ready), 0);
    chk("abort_no_wr", int'(exec_wr_req), 0);
    chk("abort_no_done", int'(done), 0);
    reset = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk);
      chk("abort_no_wr", int'(exec_wr_req), 0);
      chk("abort_no_rd", int'(exec_rd_req), 0);
      chk("abort_no_done", int'(done), 0);
      chk("abort_ready", int'(cmd_ready), 1);
    end
    chk("abort_mem", int'(mem[addr]), int'(old));
    chk("abort_rdata", int'(rdata), 0);
    chk("abort_skip", int'(skip), 0);
    m_rdata = 12'd0;
    m_skip  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 12'd0; cmd_wdata = 12'd0;
    m_rdata = 12'd0; m_skip = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_skip", int'(skip), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_rd_req", int'(exec_rd_req), 0);
    chk("rst_wr_req", int'(exec_wr_req), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    mem[12'h080] = 12'h5A5;
    run_cmd(2'b00, 12'h080, 12'h000, 1'b0);
    run_cmd(2'b01, 12'h0FF, 12'h123, 1'b0);
    chk("write_mem", int'(mem[12'h0FF]), 12'h123);
    mem[12'h010] = 12'hFFF;
    run_cmd(2'b10, 12'h010, 12'h000, 1'b0);
    mem[12'h010] = 12'h7FF;
    run_cmd(2'b10, 12'h010, 12'h000, 1'b1);
    chk("isz_mem", int'(mem[12'h010]), 12'h800);
    run_cmd(2'b11, 12'h123, 12'h456, 1'b1);
    run_cmd(2'b00, 12'h080, 12'h000, 1'b1);

    mem[12'h020] = 12'h3C3;
    reset_mid_isz(12'h020);
    run_cmd(2'b00, 12'h020, 12'h000, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      a = 12'($urandom);
      if ($urandom_range(0, 3) == 0) mem[a] = 12'hFFF;
      run_cmd(2'($urandom), a, 12'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
